gyro_spi_responder: RTL and testbench
=====================================

# gyro_spi_responder

SPI Mode-3 responder that emulates the three-axis gyro sensor's register interface on the far side of the SPI master link. It lets the gyro control path and its SPI master run in simulation or in a board loopback without the physical Pmod attached. The block decodes the gyro command byte, serves the identification, control and axis-output registers, and accepts control-register writes. It runs entirely in the system clock domain and oversamples the SPI pins.

## Interface
- SYNC_STAGES, 2: synchronizer depth applied to cs, sclk and mosi.
- WHO_AM_I_VAL, 8'hD3: value returned at address 0x0F.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-low.
- cs  in  1  SPI chip select from the master, active-low.
- sclk  in  1  SPI clock; idles high (CPOL=1).
- mosi  in  1  SPI data from the master.
- miso  out  1  SPI data to the master.
- data_x, data_y, data_z  in  16 each  axis samples (two's complement) to be served.
- data_valid  in  1  one-cycle strobe that loads a new axis snapshot.
- ctrl_reg1  out  8  current CTRL_REG1 contents.
- busy  out  1  high while the synchronized cs is low.

## Operation
- SPI mode 3, MSB first:
  - The master shifts data out on sclk falling edges and samples on sclk rising edges.
  - The responder samples mosi on synchronized sclk rises and updates miso on synchronized sclk falls.
- Command byte format:
  - bit7 RW: 1 = read.
  - bit6 MS: 1 = auto-increment the address.
  - bits5:0 = register address.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on the synchronized cs falling edge. The 3-bit bit counter clears to 0.
  - CMD -> DATA after the 8th sclk rise. RW, MS and the address latch.
  - DATA loops per byte. After each completed byte, if MS=1 the address increments modulo 64 (0x3F wraps to 0x00). If MS=0 the address holds.
  - Any state -> IDLE on the synchronized cs rise. A partially shifted byte is discarded and nothing is written.
- Read path:
  - On the sclk fall that follows the last rise of the command byte (or of the previous data byte), the tx shift register loads the addressed register and miso presents its bit7.
  - Each later fall shifts out the next bit.
- Write path:
  - On the 8th rise of a data byte, the received byte commits to the addressed register if that register is writable.
  - Writes to read-only or unmapped addresses are ignored.
- Register map:
  - 0x0F: WHO_AM_I, read-only.
  - 0x20–0x24: CTRL_REG1..5, read/write. Reset values are 0x07, 0x00, 0x00, 0x00, 0x00.
  - 0x28–0x2D: OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H, read-only, served from the snapshot.
  - All other addresses read 0x00.
- Snapshot coherency:
  - When data_valid is high and busy is low, the snapshot loads immediately.
  - When data_valid is high and busy is high, the values latch into a pending buffer, and the snapshot updates on the cycle the synchronized cs rises. A burst therefore never mixes samples.
  - If several strobes arrive during one transaction, the last one wins.
- miso is 0 when cs is high and throughout the CMD phase.

## Timing
- Reset values:
  - miso = 0, busy = 0, state = IDLE.
  - ctrl_reg1 = 0x07, CTRL_REG2..5 = 0x00.
  - snapshot and pending buffer = 0, pending flag = 0.
- Input-to-event latency: each pin edge is acted on SYNC_STAGES+1 clk cycles after it arrives. miso settles SYNC_STAGES+2 cycles after an sclk fall.
- Register write commit: visible on ctrl_reg1 SYNC_STAGES+2 cycles after the 8th data-byte rise.
- Constraint: each sclk half-period must be at least SYNC_STAGES+4 clk periods. The bench uses clk/16.
- If cs rises and data_valid is high in the same cycle, the data_valid values are applied directly to the snapshot.
- Reset asserted mid-transaction returns all state to reset values immediately. The transaction does not resume, and the next cs fall starts a fresh command.

## Structure
- gyro_spi_pkg holds:
  - the state enum (IDLE, CMD, DATA);
  - the register address constants (ADDR_WHO_AM_I, ADDR_CTRL_REG1..5, ADDR_OUT_X_L..ADDR_OUT_Z_H);
  - the CTRL reset values;
  - the RW and MS bit positions.
- Sub-module spi_pin_sync: a SYNC_STAGES flip-flop chain plus rise/fall pulse outputs. It is instantiated once each for cs and sclk. mosi uses a plain chain of equal depth so it stays aligned with sclk.

## Test plan
- Read WHO_AM_I: send command 0x8F, then 8 dummy clocks -> miso returns 0xD3 and busy drops after cs rises.
- Write then read back: send 0x20 followed by 0x0F -> ctrl_reg1 = 0x0F. Then read with command 0xA0 -> miso returns 0x0F.
- Burst read: pulse data_valid with x=0x1234, y=0xABCD, z=0x8001, then send command 0xE8 followed by 6 bytes -> miso returns 34 12 CD AB 01 80.
- Coherency: pulse data_valid with x=0x5555 during the 3rd byte of a burst -> that burst still returns 34 12 for X, and the next burst returns 55 55.
- Abort and wrap:
  - Raise cs after 4 data bits of a write to 0x21 -> CTRL_REG2 stays 0x00, and the next 0x8F read returns 0xD3.
  - A burst with command 0xFF reads 0x00 and then 0x00 from 0x00, confirming the wrap.
- Reset mid-transaction: assert rst during the DATA phase of a 0x20 write -> ctrl_reg1 = 0x07, miso = 0, busy = 0, and a following 0x8F read returns 0xD3.

Source files
------------

// File: rtl/gyro_spi_pkg.sv
// -----------------------------------------------------------------------------
// gyro_spi_pkg
// Shared definitions for the gyro SPI responder: the FSM state type, the
// emulated register addresses, CTRL register reset values and the command
// byte field positions.
// -----------------------------------------------------------------------------
package gyro_spi_pkg;

    // Transaction state: waiting for cs, shifting the command byte, data bytes.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Register map (6-bit address space)
    localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
    localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
    localparam logic [5:0] ADDR_CTRL_REG2 = 6'h21;
    localparam logic [5:0] ADDR_CTRL_REG3 = 6'h22;
    localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
    localparam logic [5:0] ADDR_CTRL_REG5 = 6'h24;
    localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

    localparam int NUM_CTRL_REGS = 5;

    // CTRL register reset values
    localparam logic [7:0] CTRL_REG1_RST = 8'h07;
    localparam logic [7:0] CTRL_REG2_RST = 8'h00;
    localparam logic [7:0] CTRL_REG3_RST = 8'h00;
    localparam logic [7:0] CTRL_REG4_RST = 8'h00;
    localparam logic [7:0] CTRL_REG5_RST = 8'h00;

    // Command byte fields
    localparam int RW_BIT = 7;  // 1 = read
    localparam int MS_BIT = 6;  // 1 = auto-increment address

    // Reset value of CTRL_REG(idx+1)
    function automatic logic [7:0] ctrl_reset_value(input int idx);
        case (idx)
            0:       return CTRL_REG1_RST;
            1:       return CTRL_REG2_RST;
            2:       return CTRL_REG3_RST;
            3:       return CTRL_REG4_RST;
            4:       return CTRL_REG5_RST;
            default: return 8'h00;
        endcase
    endfunction

    // True for the writable CTRL_REG1..5 window
    function automatic logic is_ctrl_addr(input logic [5:0] addr);
        return (addr >= ADDR_CTRL_REG1) && (addr <= ADDR_CTRL_REG5);
    endfunction

endpackage

// File: rtl/gyro_spi_responder_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Synchronizes one SPI pin into the clk domain through a STAGES-deep flop
// chain and produces single-cycle rise/fall pulses from the synchronized level.
// Ports:
//   clk, rst    system clock, asynchronous active-low reset
//   pin         raw asynchronous input
//   level       synchronized level (last chain stage)
//   rise, fall  one-cycle pulses on synchronized edges
// -----------------------------------------------------------------------------
module spi_pin_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    // Reset to the pin's idle level so no spurious edge appears after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_reg <= {STAGES{IDLE_LEVEL}};
            prev_reg  <= IDLE_LEVEL;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                chain_reg[i] <= chain_reg[i-1];
            end
            chain_reg[0] <= pin;
            prev_reg     <= chain_reg[STAGES-1];
        end
    end

    assign level = chain_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/gyro_spi_responder.sv
// -----------------------------------------------------------------------------
// gyro_spi_responder
// SPI mode-3 responder emulating the three-axis gyro register interface.
// Oversamples cs/sclk/mosi in the clk domain, decodes the command byte
// (RW, MS, 6-bit address), serves WHO_AM_I, CTRL_REG1..5 and the axis
// snapshot, and accepts CTRL register writes.
// Ports:
//   clk, rst                system clock, asynchronous active-low reset
//   cs, sclk, mosi          SPI pins from the master (cs active-low, CPOL=1)
//   miso                    SPI data to the master
//   data_x/y/z, data_valid  axis samples and their load strobe
//   ctrl_reg1               current CTRL_REG1 contents
//   busy                    synchronized cs is low
// -----------------------------------------------------------------------------
module gyro_spi_responder
    import gyro_spi_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] data_x,
    input  logic [15:0] data_y,
    input  logic [15:0] data_z,
    input  logic        data_valid,
    output logic [7:0]  ctrl_reg1,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic cs_level, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // mosi needs no edge detection; an equal-depth chain keeps it aligned
    // with the synchronized sclk so it is sampled at the matching instant.
    logic [SYNC_STAGES-1:0] mosi_chain_reg;
    logic                   mosi_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_chain_reg <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                mosi_chain_reg[i] <= mosi_chain_reg[i-1];
            end
            mosi_chain_reg[0] <= mosi;
        end
    end

    assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];
    assign busy      = ~cs_level;

    // ------------------------------------------------------------------
    // Transaction FSM and shift registers
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  tx_shift_reg;
    logic [5:0]  addr_reg;
    logic        rw_reg;
    logic        ms_reg;
    logic        miso_reg;
    logic        wr_en_reg;
    logic [5:0]  wr_addr_reg;
    logic [7:0]  wr_data_reg;

    logic [7:0]  rx_next;
    logic [7:0]  rd_data;

    assign rx_next = {rx_shift_reg[6:0], mosi_sync};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
            tx_shift_reg <= 8'h00;
            addr_reg     <= 6'h00;
            rw_reg       <= 1'b0;
            ms_reg       <= 1'b0;
            miso_reg     <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= 6'h00;
            wr_data_reg  <= 8'h00;
        end else begin
            wr_en_reg <= 1'b0;

            if (cs_rise) begin
                // Abort: any partial byte is simply dropped.
                state_reg    <= ST_IDLE;
                bit_cnt_reg  <= 3'd0;
                tx_shift_reg <= 8'h00;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_reg    <= ST_CMD;
                            bit_cnt_reg  <= 3'd0;
                            tx_shift_reg <= 8'h00;
                        end
                    end

                    ST_CMD: begin
                        if (sclk_rise) begin
                            rx_shift_reg <= rx_next;
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                rw_reg    <= rx_next[RW_BIT];
                                ms_reg    <= rx_next[MS_BIT];
                                addr_reg  <= rx_next[5:0];
                                state_reg <= ST_DATA;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (sclk_rise) begin
                            rx_shift_reg <= rx_next;
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                // Stage the write one cycle so the commit
                                // uses the address of the byte just finished.
                                if (!rw_reg && is_ctrl_addr(addr_reg)) begin
                                    wr_en_reg   <= 1'b1;
                                    wr_addr_reg <= addr_reg;
                                    wr_data_reg <= rx_next;
                                end
                                if (ms_reg) begin
                                    addr_reg <= addr_reg + 6'd1;
                                end
                            end
                        end else if (sclk_fall) begin
                            // A fall with the counter at 0 opens a new byte.
                            if (bit_cnt_reg == 3'd0) begin
                                tx_shift_reg <= rd_data;
                            end else begin
                                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                            end
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end

            // Registered output: quiet outside the data phase.
            miso_reg <= (state_reg == ST_DATA && !cs_level) ? tx_shift_reg[7] : 1'b0;
        end
    end

    assign miso = miso_reg;

    // ------------------------------------------------------------------
    // CTRL_REG1..5
    // ------------------------------------------------------------------
    logic [NUM_CTRL_REGS-1:0][7:0] ctrl_value;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRL_REGS; gi++) begin : g_ctrl
            logic [7:0] value_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    value_reg <= ctrl_reset_value(gi);
                end else if (wr_en_reg && (wr_addr_reg == ADDR_CTRL_REG1 + 6'(gi))) begin
                    value_reg <= wr_data_reg;
                end
            end

            assign ctrl_value[gi] = value_reg;
        end
    endgenerate

    assign ctrl_reg1 = ctrl_value[0];

    // ------------------------------------------------------------------
    // Axis snapshot with a pending buffer so a burst never mixes samples
    // ------------------------------------------------------------------
    logic [15:0] snap_x_reg, snap_y_reg, snap_z_reg;
    logic [15:0] pend_x_reg, pend_y_reg, pend_z_reg;
    logic        pend_flag_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_x_reg    <= 16'h0000;
            snap_y_reg    <= 16'h0000;
            snap_z_reg    <= 16'h0000;
            pend_x_reg    <= 16'h0000;
            pend_y_reg    <= 16'h0000;
            pend_z_reg    <= 16'h0000;
            pend_flag_reg <= 1'b0;
        end else if (data_valid && !busy) begin
            // Covers the cs-rise cycle too: fresh data beats a pending sample.
            snap_x_reg    <= data_x;
            snap_y_reg    <= data_y;
            snap_z_reg    <= data_z;
            pend_flag_reg <= 1'b0;
        end else if (data_valid) begin
            pend_x_reg    <= data_x;
            pend_y_reg    <= data_y;
            pend_z_reg    <= data_z;
            pend_flag_reg <= 1'b1;
        end else if (cs_rise && pend_flag_reg) begin
            snap_x_reg    <= pend_x_reg;
            snap_y_reg    <= pend_y_reg;
            snap_z_reg    <= pend_z_reg;
            pend_flag_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (addr_reg)
            ADDR_WHO_AM_I:  rd_data = WHO_AM_I_VAL;
            ADDR_CTRL_REG1: rd_data = ctrl_value[0];
            ADDR_CTRL_REG2: rd_data = ctrl_value[1];
            ADDR_CTRL_REG3: rd_data = ctrl_value[2];
            ADDR_CTRL_REG4: rd_data = ctrl_value[3];
            ADDR_CTRL_REG5: rd_data = ctrl_value[4];
            ADDR_OUT_X_L:   rd_data = snap_x_reg[7:0];
            ADDR_OUT_X_H:   rd_data = snap_x_reg[15:8];
            ADDR_OUT_Y_L:   rd_data = snap_y_reg[7:0];
            ADDR_OUT_Y_H:   rd_data = snap_y_reg[15:8];
            ADDR_OUT_Z_L:   rd_data = snap_z_reg[7:0];
            ADDR_OUT_Z_H:   rd_data = snap_z_reg[15:8];
            default:        rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_gyro_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_gyro_spi_responder
// Drives SPI mode-3 transactions at clk/16 and compares miso bytes, busy and
// ctrl_reg1 against a register-level model of the gyro.
// -----------------------------------------------------------------------------
module tb_gyro_spi_responder;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [15:0] data_x, data_y, data_z;
    logic        data_valid;
    logic [7:0]  ctrl_reg1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Transaction buffers
    logic [7:0]  tx_q [0:7];
    logic [7:0]  rx_q [0:7];

    // Reference model state
    logic [7:0]  mdl_ctrl [0:4];
    logic [15:0] mdl_snap [0:2];
    logic [15:0] mdl_pend [0:2];
    bit          mdl_pend_flag;
    logic [15:0] dv_vals  [0:2];

    // Random-loop scratch
    int         sel, nd, dvb;
    logic [5:0] r_addr;
    logic       r_rw, r_ms;

    gyro_spi_responder #(.SYNC_STAGES(2), .WHO_AM_I_VAL(8'hD3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .data_x     (data_x),
        .data_y     (data_y),
        .data_z     (data_z),
        .data_valid (data_valid),
        .ctrl_reg1  (ctrl_reg1),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register read as the gyro datasheet describes it.
    function automatic logic [7:0] model_rd(input int a);
        int k;
        if (a == 'h0F) return 8'hD3;
        if (a >= 'h20 && a <= 'h24) return mdl_ctrl[a - 'h20];
        if (a >= 'h28 && a <= 'h2D) begin
            k = a - 'h28;
            return 8'(mdl_snap[k / 2] >> (8 * (k % 2)));
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        mdl_ctrl[0] = 8'h07;
        for (int i = 1; i < 5; i++) mdl_ctrl[i] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            mdl_snap[i] = 16'h0;
            mdl_pend[i] = 16'h0;
        end
        mdl_pend_flag = 1'b0;
    endtask

    // One-cycle data_valid strobe carrying dv_vals.
    task automatic pulse_dv(input bit in_txn);
        data_x = dv_vals[0];
        data_y = dv_vals[1];
        data_z = dv_vals[2];
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (in_txn) mdl_pend[i] = dv_vals[i];
            else        mdl_snap[i] = dv_vals[i];
        end
        if (in_txn) mdl_pend_flag = 1'b1;
    endtask

    // Shift nb bits of b MSB first: drive on fall, sample miso just before rise.
    task automatic shift_bits(input logic [7:0] b, input int nb, input int idx);
        for (int i = 7; i > 7 - nb; i--) begin
            sclk = 1'b0;
            mosi = b[i];
            repeat (8) @(negedge clk);
            rx_q[idx][i] = miso;
            sclk = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    // Compare a finished transaction of nbytes complete bytes (command included).
    task automatic model_txn(input int nbytes);
        int  a;
        bit  rw, ms;
        logic [7:0] exp;
        rw = tx_q[0][7];
        ms = tx_q[0][6];
        a  = int'(tx_q[0][5:0]);
        if (nbytes >= 1) check("cmd_phase_miso", 16'(rx_q[0]), 16'h0);
        for (int i = 1; i < nbytes; i++) begin
            exp = model_rd(a);
            if (rw) begin
                check($sformatf("rd_%02h_b%0d", a, i), 16'(rx_q[i]), 16'(exp));
            end else if (a >= 'h20 && a <= 'h24) begin
                mdl_ctrl[a - 'h20] = tx_q[i];
            end
            if (ms) a = (a + 1) % 64;
        end
        if (mdl_pend_flag) begin
            for (int i = 0; i < 3; i++) mdl_snap[i] = mdl_pend[i];
            mdl_pend_flag = 1'b0;
        end
        check("ctrl_reg1", 16'(ctrl_reg1), 16'(mdl_ctrl[0]));
    endtask

    task automatic spi_xfer(input int nbytes, input int extra_bits, input int dv_byte);
        for (int i = 0; i < 8; i++) rx_q[i] = 8'h00;
        cs = 1'b0;
        repeat (10) @(negedge clk);
        for (int b = 0; b < nbytes; b++) begin
            if (b == dv_byte) pulse_dv(1'b1);
            shift_bits(tx_q[b], 8, b);
        end
        if (extra_bits > 0) shift_bits(tx_q[nbytes], extra_bits, nbytes);
        repeat (4) @(negedge clk);
        check("busy_mid", 16'(busy), 16'h1);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_idle", 16'(busy), 16'h0);
        check("miso_idle", 16'(miso), 16'h0);
        model_txn(nbytes);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
        data_x = '0; data_y = '0; data_z = '0; data_valid = 1'b0;
        for (int i = 0; i < 8; i++) tx_q[i] = 8'h00;
        model_reset();
        repeat (5) @(negedge clk);
        check("rst_miso", 16'(miso), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_ctrl_reg1", 16'(ctrl_reg1), 16'h07);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // WHO_AM_I
        tx_q[0] = 8'h8F; tx_q[1] = 8'h00;
        spi_xfer(2, 0, -1);

        // Write CTRL_REG1 then read it back
        tx_q[0] = 8'h20; tx_q[1] = 8'h0F;
        spi_xfer(2, 0, -1);
        check("ctrl_reg1_0f", 16'(ctrl_reg1), 16'h0F);
        tx_q[0] = 8'hA0; tx_q[1] = 8'h00;
        spi_xfer(2, 0, -1);

        // Burst read of the axis snapshot
        dv_vals[0] = 16'h1234; dv_vals[1] = 16'hABCD; dv_vals[2] = 16'h8001;
        pulse_dv(1'b0);
        tx_q[0] = 8'hE8;
        for (int i = 1; i < 8; i++) tx_q[i] = 8'h00;
        spi_xfer(7, 0, -1);

        // Coherency: new sample during 3rd data byte waits for cs rise
        dv_vals[0] = 16'h5555;
        spi_xfer(7, 0, 3);
        check("coh_old_x_l", 16'(rx_q[1]), 16'h34);
        spi_xfer(7, 0, -1);
        check("coh_new_x_h", 16'(rx_q[2]), 16'h55);

        // Aborted write to CTRL_REG2
        tx_q[0] = 8'h21; tx_q[1] = 8'hFF;
        spi_xfer(1, 4, -1);
        tx_q[0] = 8'hA1; tx_q[1] = 8'h00;
        spi_xfer(2, 0, -1);
        tx_q[0] = 8'h8F;
        spi_xfer(2, 0, -1);

        // Address wrap 0x3F -> 0x00
        tx_q[0] = 8'hFF; tx_q[1] = 8'h00; tx_q[2] = 8'h00;
        spi_xfer(3, 0, -1);

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       r_addr = 6'h0F;
                1:       r_addr = 6'(32 + $urandom_range(0, 4));
                2:       r_addr = 6'(40 + $urandom_range(0, 5));
                default: r_addr = 6'($urandom);
            endcase
            r_rw = 1'($urandom_range(0, 1));
            r_ms = 1'($urandom_range(0, 1));
            nd   = $urandom_range(1, 4);
            tx_q[0] = {r_rw, r_ms, r_addr};
            for (int i = 1; i <= nd; i++) tx_q[i] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 3; i++) dv_vals[i] = 16'($urandom);
                pulse_dv(1'b0);
            end
            dvb = -1;
            if ($urandom_range(0, 1) == 1) begin
                dvb = $urandom_range(0, nd);
                for (int i = 0; i < 3; i++) dv_vals[i] = 16'($urandom);
            end
            spi_xfer(nd + 1, 0, dvb);
        end

        // Reset in the middle of a CTRL_REG1 write
        tx_q[0] = 8'h20; tx_q[1] = 8'h3C;
        spi_xfer(2, 0, -1);
        check("ctrl_reg1_3c", 16'(ctrl_reg1), 16'h3C);
        tx_q[0] = 8'h20; tx_q[1] = 8'hA5;
        cs = 1'b0;
        repeat (10) @(negedge clk);
        shift_bits(tx_q[0], 8, 0);
        shift_bits(tx_q[1], 3, 1);
        rst = 1'b0;
        #1;
        check("midrst_ctrl_reg1", 16'(ctrl_reg1), 16'h07);
        check("midrst_miso", 16'(miso), 16'h0);
        check("midrst_busy", 16'(busy), 16'h0);
        model_reset();
        cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        tx_q[0] = 8'h8F; tx_q[1] = 8'h00;
        spi_xfer(2, 0, -1);
        tx_q[0] = 8'hE8;
        for (int i = 1; i < 8; i++) tx_q[i] = 8'h00;
        spi_xfer(7, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
